// File: rtl/wb_timer.sv
// wb_timer: Wishbone-slave programmable timer.
// A 16-bit prescaler produces ticks that advance a 32-bit COUNT.
// When COUNT equals COMPARE on a tick, MATCH is raised. MATCH can drive
// a level interrupt, and COUNT can optionally reload to zero at that point.
// Every bus request is acknowledged one cycle later. The acknowledge is
// single-cycle, so back-to-back requests complete at most every other cycle.

module wb_timer #(
    parameter int WB_AD_WIDTH  = 32,
    parameter int WB_DAT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_we_i,
    input  logic [WB_AD_WIDTH-1:0]    wbs_addr_i,
    input  logic [WB_DAT_WIDTH-1:0]   wbs_wdata_i,
    input  logic [WB_DAT_WIDTH/8-1:0] wbs_sel_i,
    output logic [WB_DAT_WIDTH-1:0]   wbs_rdata_o,
    output logic                      wbs_ack_o,
    output logic                      irq_o
);

    // Word offsets (byte address bits [7:2]).
    localparam logic [5:0] OFF_CTRL     = 6'h00;
    localparam logic [5:0] OFF_PRESCALE = 6'h01;
    localparam logic [5:0] OFF_COUNT    = 6'h02;
    localparam logic [5:0] OFF_COMPARE  = 6'h03;
    localparam logic [5:0] OFF_STATUS   = 6'h04;

    // Architectural registers.
    logic [2:0]  ctrl;        // bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN
    logic [15:0] prescale;
    logic [31:0] count;
    logic [31:0] compare;
    logic        match;
    logic [15:0] pre_cnt;

    // Bus decode.
    logic        req;
    logic        wr_en;
    logic        rd_en;
    logic [5:0]  offset;
    logic        wr_ctrl;
    logic        wr_prescale;
    logic        wr_count;
    logic        wr_compare;
    logic        wr_status;
    logic [31:0] rd_val;

    // Timer datapath.
    logic        en_run;
    logic        tick;
    logic        hit;
    logic        clear_match;

    // Address bits outside [7:2] are deliberately ignored.
    logic        addr_unused;
    assign addr_unused = ^{wbs_addr_i[WB_AD_WIDTH-1:8], wbs_addr_i[1:0]};

    // A new request is only accepted while no acknowledge is being presented.
    assign req    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wr_en  = req & wbs_we_i;
    assign rd_en  = req & ~wbs_we_i;
    assign offset = wbs_addr_i[7:2];

    assign wr_ctrl     = wr_en & (offset == OFF_CTRL);
    assign wr_prescale = wr_en & (offset == OFF_PRESCALE);
    assign wr_count    = wr_en & (offset == OFF_COUNT);
    assign wr_compare  = wr_en & (offset == OFF_COMPARE);
    assign wr_status   = wr_en & (offset == OFF_STATUS);

    // A CTRL write that clears EN stops the timer in that same cycle.
    assign en_run = ctrl[0] & ~(wr_ctrl & wbs_sel_i[0] & ~wbs_wdata_i[0]);
    assign tick   = en_run & (pre_cnt == prescale);
    assign hit    = tick & (count == compare);

    // W1C on STATUS bit0. A simultaneous new match takes precedence.
    assign clear_match = wr_status & wbs_sel_i[0] & wbs_wdata_i[0];

    assign irq_o = match & ctrl[2];

    // Merge write data into a 32-bit register one byte lane at a time.
    function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                                input logic [31:0] nv,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = nv[8*i +: 8];
        end
        return res;
    endfunction

    // Read multiplexer; unmapped offsets return zero.
    always_comb begin
        // NOTE: rd_val gets a default before the case so every path assigns it and no latch is inferred.
        rd_val = '0;
        case (offset)
            OFF_CTRL:     rd_val = {29'd0, ctrl};
            OFF_PRESCALE: rd_val = {16'd0, prescale};
            OFF_COUNT:    rd_val = count;
            OFF_COMPARE:  rd_val = compare;
            OFF_STATUS:   rd_val = {31'd0, match};
            default:      rd_val = '0;
        endcase
    end

    // Acknowledge and registered read data; rdata is zero outside a read ack.
    always_ff @(posedge clk) begin
        // NOTE: clocked state is assigned with <= so all registers update together from pre-edge values.
        if (rst) begin
            wbs_ack_o   <= 1'b0;
            wbs_rdata_o <= '0;
        end else begin
            wbs_ack_o   <= req;
            wbs_rdata_o <= rd_en ? rd_val : '0;
        end
    end

    // Configuration registers written from the bus with byte-lane enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl     <= '0;
            prescale <= '0;
            compare  <= '0;
        end else begin
            if (wr_ctrl && wbs_sel_i[0]) ctrl <= wbs_wdata_i[2:0];
            if (wr_prescale) begin
                if (wbs_sel_i[0]) prescale[7:0]  <= wbs_wdata_i[7:0];
                if (wbs_sel_i[1]) prescale[15:8] <= wbs_wdata_i[15:8];
            end
            if (wr_compare) compare <= merge_lanes(compare, wbs_wdata_i, wbs_sel_i);
        end
    end

    // Prescaler: wraps at PRESCALE while enabled; a PRESCALE write restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (wr_prescale) begin
            pre_cnt <= '0;
        end else if (en_run) begin
            pre_cnt <= (pre_cnt == prescale) ? 16'd0 : pre_cnt + 16'd1;
        end
    end

    // Main counter: a bus write beats the tick update, and a match may reload it.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (wr_count) begin
            count <= merge_lanes(count, wbs_wdata_i, wbs_sel_i);
        end else if (tick) begin
            count <= (hit && ctrl[1]) ? 32'd0 : count + 32'd1;
        end
    end

    // Sticky MATCH flag: set on a compare hit, cleared by a W1C to STATUS.
    always_ff @(posedge clk) begin
        if (rst) begin
            match <= 1'b0;
        end else if (hit) begin
            match <= 1'b1;
        end else if (clear_match) begin
            match <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer: self-checking bench for wb_timer.
// A transaction-level reference model runs alongside the DUT. It predicts
// the timer state and every bus response, and each cycle the bench compares
// the DUT's ack, irq and read data against those predictions. Directed
// scenarios also check their documented results against fixed values.
// A randomized phase then exercises mixed traffic against the model.

module tb_wb_timer;

    logic        clk;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
    logic        ack;
    logic        irq;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    logic [2:0]  m_ctrl  = '0;
    logic [15:0] m_pre   = '0;
    logic [15:0] m_pc    = '0;
    logic [31:0] m_count = '0;
    logic [31:0] m_cmp   = '0;
    logic        m_match = 1'b0;
    logic        m_ack   = 1'b0;
    logic [31:0] m_rdata = '0;

    int          n;
    logic [31:0] dummy;

    wb_timer #(.WB_AD_WIDTH(32), .WB_DAT_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_addr_i  (addr),
        .wbs_wdata_i (wdata),
        .wbs_sel_i   (sel),
        .wbs_rdata_o (rdata),
        .wbs_ack_o   (ack),
        .irq_o       (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // Predict the effect of one clock edge, given the inputs being driven now.
    task automatic model_step();
        logic        req;
        logic        stop;
        logic        tk;
        logic        ht;
        logic [5:0]  off;
        logic [31:0] msk;
        logic [31:0] rv;
        logic [31:0] tmp;
        logic [2:0]  n_ctrl;
        logic [15:0] n_pre;
        logic [15:0] n_pc;
        logic [31:0] n_count;
        logic [31:0] n_cmp;
        logic        n_match;
        if (rst) begin
            m_ctrl = '0; m_pre = '0; m_pc = '0; m_count = '0; m_cmp = '0;
            m_match = 1'b0; m_ack = 1'b0; m_rdata = '0;
            return;
        end
        req = cyc && stb && !m_ack;
        off = addr[7:2];
        msk = lane_mask(sel);
        rv  = 32'd0;
        if (off == 6'd0) rv = {29'd0, m_ctrl};
        else if (off == 6'd1) rv = {16'd0, m_pre};
        else if (off == 6'd2) rv = m_count;
        else if (off == 6'd3) rv = m_cmp;
        else if (off == 6'd4) rv = {31'd0, m_match};
        stop = req && we && (off == 6'd0) && sel[0] && !wdata[0];
        tk   = m_ctrl[0] && !stop && (m_pc == m_pre);
        ht   = tk && (m_count == m_cmp);
        n_pc    = (m_ctrl[0] && !stop) ? (tk ? 16'd0 : m_pc + 16'd1) : m_pc;
        n_count = tk ? ((ht && m_ctrl[1]) ? 32'd0 : m_count + 32'd1) : m_count;
        n_match = ht ? 1'b1 : m_match;
        n_ctrl  = m_ctrl;
        n_pre   = m_pre;
        n_cmp   = m_cmp;
        if (req && we) begin
            if (off == 6'd0) begin
                tmp = ({29'd0, m_ctrl} & ~msk) | (wdata & msk);
                n_ctrl = tmp[2:0];
            end else if (off == 6'd1) begin
                tmp = ({16'd0, m_pre} & ~msk) | (wdata & msk);
                n_pre = tmp[15:0];
                n_pc  = 16'd0;
            end else if (off == 6'd2) begin
                n_count = (m_count & ~msk) | (wdata & msk);
            end else if (off == 6'd3) begin
                n_cmp = (m_cmp & ~msk) | (wdata & msk);
            end else if (off == 6'd4) begin
                if (sel[0] && wdata[0] && !ht) n_match = 1'b0;
            end
        end
        m_ctrl = n_ctrl; m_pre = n_pre; m_pc = n_pc; m_count = n_count;
        m_cmp = n_cmp; m_match = n_match;
        m_ack   = req;
        m_rdata = (req && !we) ? rv : 32'd0;
    endtask

    // Advance one clock and compare the visible outputs at the following falling edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("ack", 32'(ack), 32'(m_ack));
        check("irq", 32'(irq), 32'(m_match & m_ctrl[2]));
        check("rdata", rdata, m_rdata);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) cycle();
    endtask

    task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd);
        cyc = 1'b1; stb = 1'b1; we = w; addr = {24'd0, a}; wdata = d; sel = s;
        cycle();
        check("ack_after_req", 32'(ack), 32'd1);
        rd = rdata;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; wdata = '0; sel = '0;
        cycle();
        check("ack_one_cycle", 32'(ack), 32'd0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
        logic [31:0] unused_rd;
        bus(1'b1, a, d, s, unused_rd);
    endtask

    task automatic rd_expect(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus(1'b0, a, 32'd0, 4'h0, v);
        check(tag, v, exp);
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; sel = '0;

        // Reset state.
        idle(2);
        rst = 1'b0;
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        rd_expect("reset_ctrl", 8'h00, 32'd0);
        rd_expect("reset_prescale", 8'h04, 32'd0);
        rd_expect("reset_count", 8'h08, 32'd0);
        rd_expect("reset_compare", 8'h0C, 32'd0);
        rd_expect("reset_status", 8'h10, 32'd0);

        // Byte lanes, unmapped offsets, back-to-back requests, aborted request.
        wr(8'h0C, 32'hA5A5_0001, 4'b0011);
        rd_expect("compare_lanes", 8'h0C, 32'h0000_0001);
        rd_expect("unmapped_read", 8'h20, 32'd0);
        wr(8'h20, 32'hFFFF_FFFF);
        rd_expect("unmapped_write_ignored", 8'h0C, 32'h0000_0001);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h0C;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("b2b_ack", 32'(ack), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        cyc = 1'b0; stb = 1'b0;
        cycle();
        cyc = 1'b0; stb = 1'b1; we = 1'b1; addr = 32'h0C; wdata = 32'hDEAD_BEEF; sel = 4'hF;
        cycle();
        check("no_cyc_no_ack", 32'(ack), 32'd0);
        stb = 1'b0; we = 1'b0; sel = '0;
        rd_expect("no_cyc_no_write", 8'h0C, 32'h0000_0001);

        // Prescaler 3: COUNT reaches 5 twenty cycles after the enable write.
        wr(8'h0C, 32'hFFFF_FFFF);
        wr(8'h04, 32'd3);
        wr(8'h08, 32'd0);
        wr(8'h00, 32'd1);
        idle(19);
        rd_expect("prescale_count", 8'h08, 32'd5);
        wr(8'h00, 32'd0);

        // Match with auto-reload and interrupt.
        wr(8'h04, 32'd0);
        wr(8'h0C, 32'd4);
        wr(8'h08, 32'd0);
        wr(8'h10, 32'd1);
        wr(8'h00, 32'd7);
        n = 0;
        while (irq !== 1'b1 && n < 10) begin
            cycle();
            n++;
        end
        check("match_latency", 32'(n), 32'd4);
        check("match_irq", 32'(irq), 32'd1);
        rd_expect("reload_count", 8'h08, 32'd0);
        rd_expect("status_read1", 8'h10, 32'd1);
        rd_expect("status_read2", 8'h10, 32'd1);

        // A W1C in the same cycle as a new match leaves MATCH set.
        n = 0;
        while (m_count != 32'd1 && n < 20) begin
            cycle();
            n++;
        end
        wr(8'h10, 32'd1);
        check("w1c_clears", 32'(irq), 32'd0);
        n = 0;
        while (m_count != 32'd4 && n < 20) begin
            cycle();
            n++;
        end
        wr(8'h10, 32'd1);
        check("set_wins_irq", 32'(irq), 32'd1);
        rd_expect("set_wins_status", 8'h10, 32'd1);
        // The write lands on a tick edge; one further tick occurs during the ack cycle.
        wr(8'h08, 32'h10);
        rd_expect("count_write_wins", 8'h08, 32'h11);

        // Wrap without a flag: exactly one tick from 0xFFFF_FFFF.
        wr(8'h00, 32'd0);
        wr(8'h10, 32'd1);
        wr(8'h0C, 32'd7);
        wr(8'h08, 32'hFFFF_FFFF);
        wr(8'h00, 32'd1);
        wr(8'h00, 32'd0);
        rd_expect("wrap_count", 8'h08, 32'd0);
        rd_expect("wrap_match", 8'h10, 32'd0);

        // Reset while counting and with a request pending.
        wr(8'h0C, 32'd2);
        wr(8'h08, 32'd0);
        wr(8'h00, 32'd7);
        idle(5);
        check("pre_reset_irq", 32'(irq), 32'd1);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h08; rst = 1'b1;
        cycle();
        check("reset_drops_ack", 32'(ack), 32'd0);
        check("reset_irq_low", 32'(irq), 32'd0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        cycle();
        check("reset_no_late_ack", 32'(ack), 32'd0);
        rd_expect("rst2_ctrl", 8'h00, 32'd0);
        rd_expect("rst2_prescale", 8'h04, 32'd0);
        rd_expect("rst2_count", 8'h08, 32'd0);
        rd_expect("rst2_compare", 8'h0C, 32'd0);
        rd_expect("rst2_status", 8'h10, 32'd0);

        // Randomized mixed traffic against the reference model.
        for (int it = 0; it < 300; it++) begin
            int          op;
            logic [7:0]  a;
            logic [31:0] d;
            logic [3:0]  s;
            op = int'($urandom_range(0, 9));
            a  = 8'({$urandom_range(0, 7), 2'($urandom_range(0, 3))});
            d  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
            if (a[7:2] == 6'd1) d = 32'($urandom_range(0, 4));
            s  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            if (op <= 3) begin
                bus(1'b1, a, d, s, dummy);
            end else if (op <= 6) begin
                bus(1'b0, a, 32'd0, 4'h0, dummy);
            end else if (op == 7) begin
                idle(int'($urandom_range(0, 3)));
            end else if (op == 8) begin
                cyc = 1'b0; stb = 1'b1; we = 1'b1; addr = {24'd0, a}; wdata = d; sel = s;
                cycle();
                stb = 1'b0; we = 1'b0; sel = '0;
            end else begin
                cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = {24'd0, a};
                idle(3);
                cyc = 1'b0; stb = 1'b0;
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
